acl_read_sequencer: RTL and testbench

ACL_READ_SEQUENCER -- requirements
Module: acl_read_sequencer

---
 rtl/acl_read_sequencer_pkg.sv | 47 ++++
 rtl/acl_read_sequencer_if.sv | 21 ++
 rtl/acl_period_timer.sv | 24 ++
 rtl/acl_read_sequencer.sv | 153 +++++++++++++++
 tb/tb_acl_read_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acl_read_sequencer_pkg.sv
// Shared types and constants for the accelerometer read sequencer.
// Build option ACL_TEMP_READ_EN extends each burst with the two temperature bytes.
package acl_pkg;

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_CFG     = 3'd1,
    ST_IDLE    = 3'd2,
    ST_READ    = 3'd3,
    ST_PUBLISH = 3'd4,
    ST_FAULT   = 3'd5
  } acl_state_e;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;

`ifdef ACL_TEMP_READ_EN
  localparam int N_DATA = 8;
`else
  localparam int N_DATA = 6;
`endif

  // Index of the final byte in each transaction (header bytes included).
  localparam logic [3:0] CFG_LAST  = 4'd2;
  localparam logic [3:0] READ_LAST = 4'(N_DATA + 1);

  function automatic logic [7:0] tx_byte(input logic is_read, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (is_read) begin
      if (idx == 4'd0)      b = CMD_READ;
      else if (idx == 4'd1) b = REG_XDATA_L;
    end else begin
      case (idx)
        4'd0:    b = CMD_WRITE;
        4'd1:    b = REG_POWER_CTL;
        4'd2:    b = PWR_MEASURE;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/acl_read_sequencer_if.sv
// Byte-level handshake between the sequencer and the SPI byte engine.
interface acl_spi_if;
  logic [7:0] send_data;
  logic       begin_transmission;
  logic       end_transmission;
  logic [7:0] recieved_data;

  modport master (
    output send_data,
    output begin_transmission,
    input  end_transmission,
    input  recieved_data
  );

  modport slave (
    input  send_data,
    input  begin_transmission,
    output end_transmission,
    output recieved_data
  );
endinterface

// File: rtl/acl_period_timer.sv
// Sample-period counter: counts up to PERIOD-1, holds there until restarted.
module acl_period_timer #(
  parameter int PERIOD = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tc
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                r_cnt <= '0;
    else if (i_restart)      r_cnt <= '0;
    else if (r_cnt != LAST)  r_cnt <= r_cnt + W'(1);
  end

  assign o_tc = (r_cnt == LAST);

endmodule

// File: rtl/acl_read_sequencer.sv
// Accelerometer sequencer: power-up config, periodic XYZ burst reads, byte watchdog.
// Build option ACL_TEMP_READ_EN adds the acc_t port and two temperature bytes per burst.
//
// state      | meaning
// STARTUP    | wait STARTUP_WAIT cycles after reset release
// CFG        | write POWER_CTL = measurement mode (3 bytes)
// IDLE       | wait for period terminal count and enable
// READ       | burst read from XDATA_L, stage data bytes
// PUBLISH    | copy staging to outputs, pulse data_valid
// FAULT      | byte timeout; let the engine finish its frame, then reconfigure
module acl_read_sequencer
  import acl_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000000,
  parameter int STARTUP_WAIT  = 2000000,
  parameter int TIMEOUT       = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  acl_spi_if.master   spi,
  output logic [15:0] acc_x,
  output logic [15:0] acc_y,
  output logic [15:0] acc_z,
`ifdef ACL_TEMP_READ_EN
  output logic [15:0] acc_t,
`endif
  output logic        data_valid,
  output logic        timeout_err
);

  localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_WAIT - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  acl_state_e  r_state, w_state_next;
  logic [31:0] r_wait_cnt;
  logic [31:0] r_wdog;
  logic [3:0]  r_byte_cnt;
  logic        r_begin;
  logic [7:0]  r_send_data;
  logic [7:0]  r_stage [N_DATA];
  logic [15:0] r_acc_x, r_acc_y, r_acc_z;
  logic        r_data_valid;
  logic        r_timeout_err;

  logic w_byte_done, w_is_read, w_last_byte, w_timeout;
  logic w_tx_start, w_period_restart, w_period_tc;

  acl_period_timer #(.PERIOD(SAMPLE_PERIOD)) u_period_timer (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_period_restart),
    .o_tc      (w_period_tc)
  );

  always_comb begin
    w_state_next = r_state;
    w_byte_done  = spi.end_transmission & r_begin;
    w_is_read    = (r_state == ST_READ);
    w_last_byte  = w_byte_done && (r_byte_cnt == (w_is_read ? READ_LAST : CFG_LAST));
    w_timeout    = r_begin && !w_byte_done && (r_wdog == TIMEOUT_LAST);

    case (r_state)
      ST_STARTUP: if (r_wait_cnt == STARTUP_LAST) w_state_next = ST_CFG;
      ST_CFG: begin
        if (w_timeout)        w_state_next = ST_FAULT;
        else if (w_last_byte) w_state_next = ST_IDLE;
      end
      ST_IDLE:    if (w_period_tc && enable) w_state_next = ST_READ;
      ST_READ: begin
        if (w_timeout)        w_state_next = ST_FAULT;
        else if (w_last_byte) w_state_next = ST_PUBLISH;
      end
      ST_PUBLISH: w_state_next = ST_IDLE;
      ST_FAULT:   if (r_wait_cnt == TIMEOUT_LAST) w_state_next = ST_CFG;
      default:    w_state_next = ST_STARTUP;
    endcase

    w_tx_start       = (w_state_next inside {ST_CFG, ST_READ}) && (w_state_next != r_state);
    w_period_restart = ((w_state_next == ST_READ) && (r_state != ST_READ)) ||
                       ((r_state == ST_CFG) && (w_state_next == ST_IDLE));
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_STARTUP;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait_cnt    <= '0;
      r_wdog        <= '0;
      r_byte_cnt    <= '0;
      r_begin       <= 1'b0;
      r_send_data   <= '0;
      r_acc_x       <= '0;
      r_acc_y       <= '0;
      r_acc_z       <= '0;
      r_data_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
      for (int i = 0; i < N_DATA; i++) r_stage[i] <= '0;
    end else begin
      r_wait_cnt   <= (w_state_next != r_state) ? '0 : r_wait_cnt + 32'd1;
      r_data_valid <= (r_state == ST_PUBLISH);
      if (r_state == ST_PUBLISH) begin
        r_acc_x <= {r_stage[1], r_stage[0]};
        r_acc_y <= {r_stage[3], r_stage[2]};
        r_acc_z <= {r_stage[5], r_stage[4]};
      end

      if (w_tx_start) begin
        r_begin     <= 1'b1;
        r_send_data <= tx_byte(w_state_next == ST_READ, 4'd0);
        r_byte_cnt  <= '0;
        r_wdog      <= '0;
      end else if (w_timeout) begin
        r_begin       <= 1'b0;
        r_timeout_err <= 1'b1;
        r_wdog        <= '0;
      end else if (w_byte_done) begin
        r_byte_cnt <= r_byte_cnt + 4'd1;
        r_wdog     <= '0;
        if (w_last_byte) r_begin <= 1'b0;
        else             r_send_data <= tx_byte(w_is_read, r_byte_cnt + 4'd1);
        // Bytes clocked in during the two header bytes carry no data.
        if (w_is_read) begin
          for (int i = 0; i < N_DATA; i++)
            if (r_byte_cnt == 4'(i + 2)) r_stage[i] <= spi.recieved_data;
        end
      end else if (r_begin) begin
        r_wdog <= r_wdog + 32'd1;
      end
    end
  end

`ifdef ACL_TEMP_READ_EN
  logic [15:0] r_acc_t;
  always_ff @(posedge clk) begin
    if (!rst)                       r_acc_t <= '0;
    else if (r_state == ST_PUBLISH) r_acc_t <= {r_stage[7], r_stage[6]};
  end
  assign acc_t = r_acc_t;
`endif

  assign spi.send_data          = r_send_data;
  assign spi.begin_transmission = r_begin;
  assign acc_x                  = r_acc_x;
  assign acc_y                  = r_acc_y;
  assign acc_z                  = r_acc_z;
  assign data_valid             = r_data_valid;
  assign timeout_err            = r_timeout_err;

endmodule

// File: tb/tb_acl_read_sequencer.sv
// Self-checking bench: behavioural 40-cycle byte engine with byte and sample scoreboards.
module tb_acl_read_sequencer;
  import acl_pkg::*;

  localparam int SP       = 500;
  localparam int SW       = 200;
  localparam int TO       = 100;
  localparam int BYTE_CYC = 40;
  localparam int READ_LEN = 2 + N_DATA;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] t;
  } samp_t;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic enable = 1'b0;
  logic [15:0] acc_x, acc_y, acc_z, acc_t_w;
  logic        data_valid, timeout_err;

  acl_spi_if spi();

  acl_read_sequencer #(
    .SAMPLE_PERIOD (SP),
    .STARTUP_WAIT  (SW),
    .TIMEOUT       (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .spi         (spi.master),
    .acc_x       (acc_x),
    .acc_y       (acc_y),
    .acc_z       (acc_z),
`ifdef ACL_TEMP_READ_EN
    .acc_t       (acc_t_w),
`endif
    .data_valid  (data_valid),
    .timeout_err (timeout_err)
  );

`ifndef ACL_TEMP_READ_EN
  assign acc_t_w = 16'h0000;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] q_bytes [$];
  samp_t      q_samp  [$];
  logic [7:0] resp [N_DATA];

  int   withhold_idx = -1;
  bit   expect_abort = 1'b0;
  int   spur_req = 0, spur_ack = 0;
  bit   busy = 1'b0, win_open = 1'b0;
  int   cnt = 0, idx = 0, win_bytes = 0, last_done_cyc = 0;
  logic [7:0] win_first = 8'h00;
  logic [7:0] cur = 8'h00;

  // Byte engine plus output monitor, run once per falling edge.
  task automatic engine_step();
    logic [7:0] e;
    samp_t s;
    int exp_len;
    spi.end_transmission = 1'b0;
    if (data_valid === 1'b1) begin
      total++;
      if (q_samp.size() == 0) begin
        bad++;
        $display("FAIL dv_unexpected got=1 exp=0 at cyc %0d", cyc);
      end else begin
        s = q_samp.pop_front();
        if ({acc_x, acc_y, acc_z} !== {s.x, s.y, s.z}) begin
          bad++;
          $display("FAIL sample_xyz got=%h_%h_%h exp=%h_%h_%h", acc_x, acc_y, acc_z, s.x, s.y, s.z);
        end
`ifdef ACL_TEMP_READ_EN
        if (acc_t_w !== s.t) begin
          bad++;
          $display("FAIL sample_t got=%h exp=%h", acc_t_w, s.t);
        end
`endif
      end
    end
    if (spi.begin_transmission !== 1'b1) begin
      if (win_open && !expect_abort) begin
        exp_len = (win_first == CMD_WRITE) ? 3 : READ_LEN;
        total++;
        if (win_bytes != exp_len) begin
          bad++;
          $display("FAIL window_len got=%0d exp=%0d", win_bytes, exp_len);
        end
      end
      win_open = 1'b0;
      busy     = 1'b0;
      idx      = 0;
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        spi.end_transmission = 1'b1;
        spi.recieved_data    = 8'h55;
      end
    end else begin
      if (!win_open) begin
        win_open  = 1'b1;
        win_bytes = 0;
        win_first = spi.send_data;
      end
      if (!busy) begin
        busy = 1'b1;
        cnt  = 0;
        cur  = spi.send_data;
        win_bytes++;
        total++;
        if (q_bytes.size() == 0) begin
          bad++;
          $display("FAIL byte_unexpected got=%h exp=none", cur);
        end else begin
          e = q_bytes.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL byte_value got=%h exp=%h", cur, e);
          end
        end
      end else if (idx != withhold_idx) begin
        cnt++;
        if (cnt == BYTE_CYC - 1) begin
          spi.end_transmission = 1'b1;
          spi.recieved_data    = (idx >= 2) ? resp[idx-2] : 8'hA5;
          busy          = 1'b0;
          idx++;
          last_done_cyc = cyc;
        end
      end
    end
  endtask

  task automatic push_cfg();
    q_bytes.push_back(8'h0A);
    q_bytes.push_back(8'h2D);
    q_bytes.push_back(8'h02);
  endtask

  task automatic push_read(input bit with_sample);
    samp_t s;
    q_bytes.push_back(8'h0B);
    q_bytes.push_back(8'h0E);
    for (int i = 0; i < N_DATA; i++) q_bytes.push_back(8'h00);
    if (with_sample) begin
      s.x = {resp[1], resp[0]};
      s.y = {resp[3], resp[2]};
      s.z = {resp[5], resp[4]};
      s.t = (N_DATA > 6) ? {resp[N_DATA-1], resp[N_DATA-2]} : 16'h0000;
      q_samp.push_back(s);
    end
  endtask

  task automatic wait_begin(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spi.begin_transmission === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_dv(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    total++;
    if ({spi.send_data, spi.begin_transmission, data_valid, timeout_err} !== 11'd0) begin
      bad++;
      $display("FAIL reset_ctrl got=%h/%b/%b/%b exp=0", spi.send_data, spi.begin_transmission,
               data_valid, timeout_err);
    end
    total++;
    if ({acc_x, acc_y, acc_z, acc_t_w} !== 64'd0) begin
      bad++;
      $display("FAIL reset_acc got=%h_%h_%h_%h exp=0", acc_x, acc_y, acc_z, acc_t_w);
    end
  endtask

  task automatic test_startup_cfg();
    bit ok;
    int t0;
    push_cfg();
    rst = 1'b1;
    t0  = cyc;
    wait_begin(1'b1, SW + 20, ok);
    total++;
    if (!ok || (cyc - t0) < SW - 2 || (cyc - t0) > SW + 2) begin
      bad++;
      $display("FAIL startup_wait got=%0d ok=%0d exp=%0d", cyc - t0, ok, SW);
    end
    wait_begin(1'b0, 3 * (BYTE_CYC + 2) + 20, ok);
    repeat (2) @(negedge clk);
    total++;
    if (!ok || q_bytes.size() != 0) begin
      bad++;
      $display("FAIL cfg_done got=ok%0d_left%0d exp=ok1_left0", ok, q_bytes.size());
    end
  endtask

  task automatic test_single_read(output int at);
    bit ok;
    resp[0] = 8'h34; resp[1] = 8'h12; resp[2] = 8'hFF;
    resp[3] = 8'hFF; resp[4] = 8'h00; resp[5] = 8'h80;
    for (int i = 6; i < N_DATA; i++) resp[i] = (i == 6) ? 8'h56 : 8'h07;
    push_read(1'b1);
    enable = 1'b1;
    wait_dv(SP + 600, ok, at);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_read_dv got=none exp=pulse");
    end
    @(negedge clk);
    total++;
    if (acc_x !== 16'h1234 || acc_y !== 16'hFFFF || acc_z !== 16'h8000) begin
      bad++;
      $display("FAIL single_read_acc got=%h_%h_%h exp=1234_ffff_8000", acc_x, acc_y, acc_z);
    end
  endtask

  task automatic test_periodic(input int first_at);
    bit ok;
    int prev, at;
    prev = first_at;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < N_DATA; i++) resp[i] = 8'($urandom_range(0, 255));
      push_read(1'b1);
      wait_dv(SP + 20, ok, at);
      total++;
      if (!ok || (at - prev) != SP) begin
        bad++;
        $display("FAIL period_%0d got=%0d ok=%0d exp=%0d", n, at - prev, ok, SP);
      end
      prev = at;
    end
  endtask

  task automatic test_enable_hold();
    bit ok;
    int high_cnt, at;
    enable   = 1'b0;
    high_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 900) spur_req++;
      if (spi.begin_transmission !== 1'b0) high_cnt++;
    end
    total++;
    if (high_cnt != 0) begin
      bad++;
      $display("FAIL enable_hold got=%0d exp=0 busy cycles", high_cnt);
    end
    for (int i = 0; i < N_DATA; i++) resp[i] = 8'(8'h11 * (i + 1));
    push_read(1'b1);
    enable = 1'b1;
    @(negedge clk);
    total++;
    if (spi.begin_transmission !== 1'b1) begin
      bad++;
      $display("FAIL enable_resume got=%b exp=1", spi.begin_transmission);
    end
    enable = 1'b0;
    wait_dv(READ_LEN * (BYTE_CYC + 2) + 20, ok, at);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midburst_disable got=none exp=pulse");
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t_err;
    withhold_idx = 2;
    expect_abort = 1'b1;
    push_read(1'b0);
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    t_err  = cyc;
    enable = 1'b0;
    total++;
    if (!ok || (t_err - last_done_cyc) < TO - 2 || (t_err - last_done_cyc) > TO + 3) begin
      bad++;
      $display("FAIL timeout_time got=%0d ok=%0d exp=%0d", t_err - last_done_cyc, ok, TO);
    end
    total++;
    if (spi.begin_transmission !== 1'b0) begin
      bad++;
      $display("FAIL timeout_drop got=%b exp=0", spi.begin_transmission);
    end
    q_bytes.delete();
    push_cfg();
    withhold_idx = -1;
    repeat (2) @(negedge clk);
    expect_abort = 1'b0;
    wait_begin(1'b1, TO + 20, ok);
    total++;
    if (!ok || (cyc - t_err) < TO - 3 || (cyc - t_err) > TO + 3) begin
      bad++;
      $display("FAIL fault_wait got=%0d ok=%0d exp=%0d", cyc - t_err, ok, TO);
    end
    wait_begin(1'b0, 3 * (BYTE_CYC + 2) + 20, ok);
    repeat (2) @(negedge clk);
    total++;
    if (!ok || q_bytes.size() != 0 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL recfg got=ok%0d_left%0d_err%b exp=ok1_left0_err1", ok, q_bytes.size(),
               timeout_err);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    expect_abort = 1'b1;
    push_read(1'b0);
    wait_begin(1'b1, SP + 50, ok);
    enable = 1'b1;
    if (!ok) wait_begin(1'b1, 5, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midread_start got=none exp=begin");
    end
    repeat (100) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({spi.begin_transmission, spi.send_data, data_valid, timeout_err} !== 11'd0) begin
      bad++;
      $display("FAIL midread_reset got=%b/%h/%b/%b exp=0", spi.begin_transmission,
               spi.send_data, data_valid, timeout_err);
    end
    total++;
    if ({acc_x, acc_y, acc_z} !== 48'd0) begin
      bad++;
      $display("FAIL midread_acc got=%h_%h_%h exp=0", acc_x, acc_y, acc_z);
    end
    repeat (10) @(negedge clk);
    q_bytes.delete();
  endtask

  initial begin
    int first_at;
    spi.end_transmission = 1'b0;
    spi.recieved_data    = 8'h00;
    fork
      forever begin
        @(negedge clk);
        engine_step();
      end
    join_none
    test_reset();
    test_startup_cfg();
    test_single_read(first_at);
    test_periodic(first_at);
    test_enable_hold();
    test_timeout();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
